// File: rtl/output_scan_selector_if.sv
// Channel/select/mode inputs and registered display outputs of the scan selector.
interface output_scan_selector_if #(
   parameter int NCH  = 4,
   parameter int SELW = 2,
   parameter int DW   = 8
);
   logic [NCH*DW-1:0] ch_data;
   logic [SELW-1:0]   sel;
   logic [1:0]        mode;
   logic              step;
   logic [DW-1:0]     out;
   logic [SELW-1:0]   out_ch;
   logic              changed;

   modport master (
      output ch_data, sel, mode, step,
      input  out, out_ch, changed
   );

   modport slave (
      input  ch_data, sel, mode, step,
      output out, out_ch, changed
   );
endinterface

// File: rtl/output_scan_selector.sv
// Display-output selector: manual select, timed auto-scan with step button, freeze.
// mode | meaning
// 00   | manual: index follows sel, dwell counter cleared
// 01   | auto-scan: advance on dwell expiry or step rise
// 10   | freeze: outputs, index and counter hold
// 11   | manual (alias of 00)
module output_scan_selector #(
   parameter int NCH   = 4,
   parameter int SELW  = 2,
   parameter int DW    = 8,
   parameter int DWELL = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   output_scan_selector_if.slave bus
);
   localparam int               CW       = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
   localparam logic [SELW-1:0]  IDX_LAST = SELW'(NCH - 1);
   localparam logic [SELW:0]    NCH_W    = (SELW + 1)'(NCH);

   typedef enum logic [1:0] {
      M_MANUAL     = 2'b00,
      M_AUTO       = 2'b01,
      M_FREEZE     = 2'b10,
      M_MANUAL_ALT = 2'b11
   } mode_t;

   mode_t           mode;
   logic [SELW-1:0] index, idx_base, idx_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            step_q, step_ev;
   logic [DW-1:0]   ch [NCH];
   logic [DW-1:0]   data_nxt;
   logic [DW-1:0]   out_r;
   logic [SELW-1:0] out_ch_r;
   logic            changed_r;

   assign mode    = mode_t'(bus.mode);
   assign step_ev = bus.step & ~step_q;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      assign ch[k] = bus.ch_data[k*DW +: DW];
   end

   always_comb begin
      // an out-of-range manual index is wrapped to 0 on the first auto cycle
      idx_base = ({1'b0, index} >= NCH_W) ? '0 : index;
      idx_nxt  = index;
      cnt_nxt  = cnt;
      case (mode)
         M_AUTO: begin
            if ((cnt == CNT_LAST) || step_ev) begin
               idx_nxt = (idx_base == IDX_LAST) ? '0 : idx_base + 1'b1;
               cnt_nxt = '0;
            end else begin
               idx_nxt = idx_base;
               cnt_nxt = cnt + 1'b1;
            end
         end
         M_FREEZE: begin
         end
         default: begin
            idx_nxt = bus.sel;
            cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      data_nxt = '0;
      for (int k = 0; k < NCH; k++) begin
         if (idx_nxt == SELW'(k)) data_nxt = ch[k];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         index     <= '0;
         cnt       <= '0;
         step_q    <= 1'b0;
         out_r     <= '0;
         out_ch_r  <= '0;
         changed_r <= 1'b0;
      end else begin
         step_q <= bus.step;
         if (mode != M_FREEZE) begin
            index     <= idx_nxt;
            cnt       <= cnt_nxt;
            out_r     <= data_nxt;
            out_ch_r  <= idx_nxt;
            changed_r <= (data_nxt != out_r);
         end else begin
            changed_r <= 1'b0;
         end
      end
   end

   assign bus.out     = out_r;
   assign bus.out_ch  = out_ch_r;
   assign bus.changed = changed_r;
endmodule

// File: tb/tb_output_scan_selector.sv
// Scoreboard bench for output_scan_selector: directed scenarios plus random traffic.
module tb_output_scan_selector;
   localparam int NCH   = 3;
   localparam int SELW  = 2;
   localparam int DW    = 8;
   localparam int DWELL = 4;
   localparam logic [NCH*DW-1:0] D0 = 24'h33_22_11;

   typedef struct packed {
      logic [DW-1:0]   out;
      logic [SELW-1:0] out_ch;
      logic            changed;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_scan_selector_if #(.NCH(NCH), .SELW(SELW), .DW(DW)) bus ();

   output_scan_selector #(.NCH(NCH), .SELW(SELW), .DW(DW), .DWELL(DWELL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t q[$];
   exp_t got_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // reference state: what is shown, which channel, time spent on it
   int m_idx  = 0;
   int m_cnt  = 0;
   int m_out  = 0;
   bit m_prev = 1'b0;

   task automatic apply(input bit r, input bit [1:0] md, input int s, input bit st,
                        input logic [NCH*DW-1:0] cd);
      exp_t e;
      bit   ev;
      int   nv;
      @(negedge clk);
      rst         = r;
      bus.mode    = md;
      bus.sel     = SELW'(s);
      bus.step    = st;
      bus.ch_data = cd;
      if (r) begin
         m_idx = 0; m_cnt = 0; m_out = 0; m_prev = 1'b0;
         e = '0;
      end else begin
         ev     = st && !m_prev;
         m_prev = st;
         if (md == 2'b10) begin
            e.out     = DW'(m_out);
            e.out_ch  = SELW'(m_idx);
            e.changed = 1'b0;
         end else begin
            if (md == 2'b01) begin
               if (m_idx >= NCH) m_idx = 0;
               if (m_cnt == DWELL - 1 || ev) begin
                  m_idx = (m_idx + 1) % NCH;
                  m_cnt = 0;
               end else begin
                  m_cnt++;
               end
            end else begin
               m_idx = s;
               m_cnt = 0;
            end
            nv = (m_idx < NCH) ? int'((cd >> (m_idx * DW)) & 24'hFF) : 0;
            e.changed = (nv != m_out);
            m_out     = nv;
            e.out     = DW'(nv);
            e.out_ch  = SELW'(m_idx);
         end
      end
      q.push_back(e);
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      if (q.size() > 0) begin
         got_e = q.pop_front();
         checks++;
         if (bus.out !== got_e.out || bus.out_ch !== got_e.out_ch || bus.changed !== got_e.changed) begin
            errors++;
            $display("FAIL cyc%0d out/out_ch/changed got %h/%0d/%b want %h/%0d/%b", cyc,
                     bus.out, bus.out_ch, bus.changed, got_e.out, got_e.out_ch, got_e.changed);
         end
      end
   end

   initial begin
      logic [NCH*DW-1:0] cd;
      bit [1:0] md;
      int       s;
      bit       st;
      bit       r;

      rst = 1'b1; bus.mode = 2'b00; bus.sel = '0; bus.step = 1'b0; bus.ch_data = D0;

      repeat (2) apply(1, 2'b00, 0, 0, D0);
      repeat (3) apply(0, 2'b00, 2, 0, D0);
      apply(0, 2'b00, 0, 0, D0);
      repeat (14) apply(0, 2'b01, 0, 0, D0);
      // step rise coinciding with expiry, then a long held press
      apply(0, 2'b00, 0, 0, D0);
      repeat (3) apply(0, 2'b01, 0, 0, D0);
      repeat (10) apply(0, 2'b01, 0, 1, D0);
      repeat (3) apply(0, 2'b01, 0, 0, D0);
      // freeze ignores channel data, release to manual shows it
      apply(0, 2'b00, 0, 0, D0);
      apply(0, 2'b10, 0, 0, D0);
      repeat (3) apply(0, 2'b10, 1, 1, 24'h33_22_AA);
      repeat (2) apply(0, 2'b11, 0, 0, 24'h33_22_AA);
      // out-of-range select, then auto wraps to channel 0
      repeat (2) apply(0, 2'b00, 3, 0, D0);
      repeat (3) apply(0, 2'b01, 3, 0, D0);
      // auto -> freeze -> auto resumes held dwell count
      repeat (2) apply(0, 2'b01, 0, 0, D0);
      repeat (3) apply(0, 2'b10, 0, 0, D0);
      repeat (5) apply(0, 2'b01, 0, 0, D0);
      // reset mid auto-scan
      apply(0, 2'b00, 2, 0, D0);
      repeat (2) apply(0, 2'b01, 2, 0, D0);
      apply(1, 2'b01, 2, 0, D0);
      repeat (3) apply(0, 2'b01, 2, 0, D0);

      cd = D0; md = 2'b01; s = 0; st = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) md = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 3);
         if ($urandom_range(0, 4) == 0) st = ~st;
         if ($urandom_range(0, 5) == 0)
            cd[$urandom_range(0, NCH-1)*DW +: DW] = 8'($urandom_range(0, 3) * 8'h11);
         r = ($urandom_range(0, 199) == 0);
         apply(r, md, s, st, cd);
      end

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
